// File: rtl/dma_grant_seq.sv
// Round-robin DMA grant sequencer: owns last-owner state, issues a one-hot
// grant for a tenure of up to BURST transfers and acknowledges each transfer.
module dma_grant_seq #(
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned BURST    = 4,
   parameter int unsigned CW       = $clog2(CHANNELS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] req,
   input  logic                xfer_done,
   output logic [CHANNELS-1:0] grant,
   output logic [CW-1:0]       chan,
   output logic                start,
   output logic                busy,
   output logic [CHANNELS-1:0] ack
);

   localparam int unsigned CNT_W = (BURST > 1) ? $clog2(BURST) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST - 1);

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   state_t               state, state_nxt;
   logic [CHANNELS-1:0]  last, last_nxt;
   logic [CNT_W-1:0]     cnt, cnt_nxt;
   logic [CHANNELS-1:0]  grant_nxt, ack_nxt;
   logic [CW-1:0]        chan_nxt;
   logic                 start_nxt, busy_nxt;

   logic [CHANNELS-1:0]  pick_hot;
   logic [CW-1:0]        pick_idx;
   logic                 found;
   int unsigned          idx;

   // Round-robin pick: lowest requester when no history, otherwise first
   // requester above the last owner with wrap; the last owner is scanned last.
   always_comb begin
      pick_hot = '0;
      pick_idx = '0;
      found    = 1'b0;
      idx      = 0;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
         if (last == '0) begin
            idx = k;
         end else begin
            idx = (32'(chan) + k + 1) % CHANNELS;
         end
         if (!found && req[CW'(idx)]) begin
            found              = 1'b1;
            pick_hot[CW'(idx)] = 1'b1;
            pick_idx           = CW'(idx);
         end
      end
   end

   // Next-state and next-output logic for the tenure sequencer.
   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      cnt_nxt   = cnt;
      grant_nxt = grant;
      chan_nxt  = chan;
      busy_nxt  = busy;
      start_nxt = 1'b0;
      ack_nxt   = '0;
      unique case (state)
         IDLE: begin
            if (req != '0) begin
               state_nxt = GRANT;
               grant_nxt = pick_hot;
               chan_nxt  = pick_idx;
               start_nxt = 1'b1;
               busy_nxt  = 1'b1;
               cnt_nxt   = '0;
            end
         end
         GRANT: begin
            if (xfer_done) begin
               ack_nxt[chan] = 1'b1;
               if ((cnt == CNT_LAST) || !req[chan]) begin
                  state_nxt = IDLE;
                  grant_nxt = '0;
                  busy_nxt  = 1'b0;
                  last_nxt  = grant;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State and registered outputs; synchronous reset dominates all inputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         last  <= '0;
         cnt   <= '0;
         grant <= '0;
         chan  <= '0;
         start <= 1'b0;
         busy  <= 1'b0;
         ack   <= '0;
      end else begin
         state <= state_nxt;
         last  <= last_nxt;
         cnt   <= cnt_nxt;
         grant <= grant_nxt;
         chan  <= chan_nxt;
         start <= start_nxt;
         busy  <= busy_nxt;
         ack   <= ack_nxt;
      end
   end

endmodule

// File: tb/tb_dma_grant_seq.sv
// Directed self-checking bench for dma_grant_seq (CHANNELS=4, BURST=4).
module tb_dma_grant_seq;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic       xfer_done;
   logic [3:0] grant;
   logic [1:0] chan;
   logic       start;
   logic       busy;
   logic [3:0] ack;

   int checks = 0;
   int errors = 0;

   dma_grant_seq #(.CHANNELS(4), .BURST(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .xfer_done (xfer_done),
      .grant     (grant),
      .chan      (chan),
      .start     (start),
      .busy      (busy),
      .ack       (ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; outputs are sampled 1 ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; req = '0; xfer_done = 1'b0;
      step(); step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 4'b1111; xfer_done = 1'b1;
      step(); step();
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got=%b exp=%b", grant, 4'b0000); end
      checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack got=%b exp=%b", ack, 4'b0000); end
      checks++; if ({start, busy, chan} !== 4'b0000) begin errors++; $display("FAIL reset_ctrl got=%b exp=%b", {start, busy, chan}, 4'b0000); end
      rst = 1'b0; req = '0; xfer_done = 1'b0;
   endtask

   // Sole requester: full burst with done asserted from the start cycle on.
   task automatic test_single();
      do_reset();
      req = 4'b0100;
      step();
      checks++; if ({grant, chan, start, busy} !== {4'b0100, 2'd2, 1'b1, 1'b1}) begin errors++; $display("FAIL single_start got=%b/%0d/%b/%b exp=0100/2/1/1", grant, chan, start, busy); end
      for (int i = 0; i < 4; i++) begin
         xfer_done = 1'b1;
         step();
         xfer_done = 1'b0;
         checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL single_ack%0d got=%b exp=%b", i, ack, 4'b0100); end
         checks++; if (start !== 1'b0) begin errors++; $display("FAIL single_start_clear%0d got=%b exp=0", i, start); end
         if (i < 3) begin
            checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL single_hold%0d got=%b exp=%b", i, grant, 4'b0100); end
            step();
            checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL single_ack_pulse%0d got=%b exp=%b", i, ack, 4'b0000); end
         end else begin
            checks++; if ({grant, busy} !== 5'b00000) begin errors++; $display("FAIL single_release got=%b/%b exp=0000/0", grant, busy); end
         end
      end
      step();
      checks++; if ({grant, start, ack} !== {4'b0100, 1'b1, 4'b0000}) begin errors++; $display("FAIL single_regrant got=%b/%b/%b exp=0100/1/0000", grant, start, ack); end
      req = '0;
   endtask

   // All clients requesting: every tenure runs full length in rotation.
   task automatic test_round_robin();
      logic [3:0] exp_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      do_reset();
      req = 4'b1111;
      step();
      for (int t = 0; t < 5; t++) begin
         checks++; if (grant !== exp_seq[t]) begin errors++; $display("FAIL rr_grant%0d got=%b exp=%b", t, grant, exp_seq[t]); end
         if (t < 4) begin
            xfer_done = 1'b1;
            for (int i = 0; i < 4; i++) step();
            xfer_done = 1'b0;
            checks++; if ({grant, ack} !== {4'b0000, exp_seq[t]}) begin errors++; $display("FAIL rr_gap%0d got=%b/%b exp=0000/%b", t, grant, ack, exp_seq[t]); end
            step();
         end
      end
      req = '0;
   endtask

   // Wrap-around past the top channel and skipping of idle channels.
   task automatic test_wrap();
      do_reset();
      req = 4'b0010;
      step();
      checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL wrap_first got=%b exp=%b", grant, 4'b0010); end
      req = 4'b0001; xfer_done = 1'b1;
      step();
      checks++; if ({grant, ack} !== {4'b0000, 4'b0010}) begin errors++; $display("FAIL wrap_rel1 got=%b/%b exp=0000/0010", grant, ack); end
      req = 4'b0011; xfer_done = 1'b0;
      step();
      checks++; if ({grant, chan} !== {4'b0001, 2'd0}) begin errors++; $display("FAIL wrap_to0 got=%b/%0d exp=0001/0", grant, chan); end
      req = 4'b1000; xfer_done = 1'b1;
      step();
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL wrap_rel2 got=%b exp=%b", grant, 4'b0000); end
      req = 4'b1001; xfer_done = 1'b0;
      step();
      checks++; if ({grant, chan} !== {4'b1000, 2'd3}) begin errors++; $display("FAIL wrap_to3 got=%b/%0d exp=1000/3", grant, chan); end
      req = '0;
   endtask

   // Owner drops req: grant held with no done, released on the next done.
   task automatic test_drop();
      int acks = 0;
      do_reset();
      req = 4'b0100;
      step();
      xfer_done = 1'b1;
      step();
      xfer_done = 1'b0; req = 4'b0000;
      if (ack == 4'b0100) acks++;
      for (int i = 0; i < 6; i++) begin
         step();
         if (ack != 4'b0000) acks++;
      end
      checks++; if ({grant, busy} !== {4'b0100, 1'b1}) begin errors++; $display("FAIL drop_hold got=%b/%b exp=0100/1", grant, busy); end
      xfer_done = 1'b1;
      step();
      xfer_done = 1'b0;
      if (ack == 4'b0100) acks++;
      checks++; if ({grant, busy} !== 5'b00000) begin errors++; $display("FAIL drop_release got=%b/%b exp=0000/0", grant, busy); end
      step(); step();
      if (ack != 4'b0000) acks++;
      checks++; if (acks !== 2) begin errors++; $display("FAIL drop_ack_count got=%0d exp=2", acks); end
   endtask

   // xfer_done while idle produces nothing.
   task automatic test_idle_done();
      int acks = 0;
      do_reset();
      xfer_done = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         if (ack != 4'b0000 || grant != 4'b0000) acks++;
      end
      xfer_done = 1'b0;
      checks++; if (acks !== 0) begin errors++; $display("FAIL idle_done got=%0d exp=0", acks); end
   endtask

   // Reset mid-tenure with a coincident done clears outputs and history.
   task automatic test_rst_mid();
      do_reset();
      req = 4'b0001;
      step();
      req = 4'b0000; xfer_done = 1'b1;
      step();
      xfer_done = 1'b0; req = 4'b0100;
      step();
      checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL rstmid_pre got=%b exp=%b", grant, 4'b0100); end
      rst = 1'b1; xfer_done = 1'b1; req = 4'b0101;
      step();
      checks++; if ({grant, ack, start, busy, chan} !== 12'd0) begin errors++; $display("FAIL rstmid_zero got=%b/%b/%b/%b/%0d exp=all zero", grant, ack, start, busy, chan); end
      rst = 1'b0; xfer_done = 1'b0;
      step();
      checks++; if ({grant, ack} !== {4'b0001, 4'b0000}) begin errors++; $display("FAIL rstmid_lowest got=%b/%b exp=0001/0000", grant, ack); end
      req = '0;
   endtask

   // Random traffic: one-hot grant/ack, ack only after a done, <=BURST acks.
   task automatic test_random();
      int bad_hot = 0, bad_ack = 0, bad_burst = 0, tenure_acks = 0;
      logic prev_done = 1'b0;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         req = 4'($urandom_range(0, 15));
         xfer_done = ($urandom_range(0, 2) == 0);
         prev_done = xfer_done;
         step();
         if (!$onehot0(grant) || !$onehot0(ack)) bad_hot++;
         if (ack != 4'b0000 && !prev_done) bad_ack++;
         if (start) tenure_acks = 0;
         if (ack != 4'b0000) tenure_acks++;
         if (tenure_acks > 4) bad_burst++;
      end
      req = '0; xfer_done = 1'b0;
      checks++; if (bad_hot !== 0) begin errors++; $display("FAIL rand_onehot got=%0d exp=0", bad_hot); end
      checks++; if (bad_ack !== 0) begin errors++; $display("FAIL rand_ack_cause got=%0d exp=0", bad_ack); end
      checks++; if (bad_burst !== 0) begin errors++; $display("FAIL rand_burst got=%0d exp=0", bad_burst); end
   endtask

   initial begin
      rst = 1'b1; req = '0; xfer_done = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_wrap();
      test_drop();
      test_idle_done();
      test_rst_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
